// File: rtl/soc2_ram_pkg.sv
// Shared types and constants for the soc2 pipelined RAM slave.
package soc2_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/soc2_ram_pipe_if.sv
// Avalon-MM style slave bus for the soc2 RAM, including the clock enable.
interface soc2_ram_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic                  clken;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;
  logic                  init_done;
  logic                  err_oor;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken,
    input  readdata, readdatavalid, waitrequest, init_done, err_oor
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken,
    output readdata, readdatavalid, waitrequest, init_done, err_oor
  );
endinterface

// File: rtl/soc2_ram_core.sv
// Byte-enabled single-port array with registered read and new-data read-during-write.
module soc2_ram_core
  import soc2_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 10240,
  parameter int unsigned ADDR_W = 14,
  localparam int unsigned BE_W  = byte_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  input  logic              rd_zero,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word_c;

  // Array contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Merge any same-cycle write so the read sees new data.
  always_comb begin
    rd_word_c = mem[addr];
    for (int i = 0; i < int'(BE_W); i++) begin
      if (we && be[i]) rd_word_c[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (rd) q <= rd_zero ? '0 : rd_word_c;
  end

endmodule

// File: rtl/soc2_ram_pipe.sv
// Pipelined RAM slave: power-up clear FSM, handshake, range check and read-latency pipeline.
module soc2_ram_pipe
  import soc2_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 10240,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  soc2_ram_pipe_if.slave bus
);

  localparam int unsigned BE_W      = byte_lanes(DATA_W);
  localparam ram_state_e  RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("soc2_ram_pipe: DATA_W must be a multiple of 8");
  end
  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("soc2_ram_pipe: READ_LATENCY must be 1 or 2");
  end
  if ((64'(1) << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("soc2_ram_pipe: 2**ADDR_W must cover DEPTH");
  end

  ram_state_e        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              err_q;
  logic              rd_v0;
  logic [DATA_W-1:0] core_q;
  logic              vld_c;

  logic              clearing_c;
  logic              wait_c;
  logic              in_range_c;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic              clr_last_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [BE_W-1:0]   mem_be_c;

  assign clearing_c = (state == CLEAR);
  assign wait_c     = clearing_c | ~bus.clken;
  assign in_range_c = 32'(bus.address) < DEPTH;
  assign wr_acc_c   = bus.chipselect & bus.write & ~wait_c;
  assign rd_acc_c   = bus.chipselect & bus.read & ~bus.write & ~wait_c;
  assign clr_last_c = (clr_cnt == ADDR_W'(DEPTH - 1));

  // Clear sequencer: one zero word per enabled cycle, then READY until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else if (bus.clken && clearing_c) begin
      if (clr_last_c) state <= READY;
      clr_cnt <= clr_last_c ? '0 : clr_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 err_q <= 1'b0;
    else if ((wr_acc_c | rd_acc_c) & ~in_range_c) err_q <= 1'b1;
  end

  // The clear engine owns the single array port while active.
  assign mem_we_c    = (clearing_c & bus.clken) | (wr_acc_c & in_range_c);
  assign mem_addr_c  = clearing_c ? clr_cnt : bus.address;
  assign mem_wdata_c = clearing_c ? '0 : bus.writedata;
  assign mem_be_c    = clearing_c ? '1 : bus.byteenable;

  soc2_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (reset_n),
    .we      (mem_we_c),
    .be      (mem_be_c),
    .addr    (mem_addr_c),
    .wdata   (mem_wdata_c),
    .rd      (rd_acc_c),
    .rd_zero (~in_range_c),
    .q       (core_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       rd_v0 <= 1'b0;
    else if (bus.clken) rd_v0 <= rd_acc_c;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.readdata = core_q;
    assign vld_c        = rd_v0;
  end else begin : g_lat2
    logic              rd_v1;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_v1   <= 1'b0;
        rdata_q <= '0;
      end else if (bus.clken) begin
        rd_v1 <= rd_v0;
        if (rd_v0) rdata_q <= core_q;
      end
    end

    assign bus.readdata = rdata_q;
    assign vld_c        = rd_v1;
  end

  // A frozen pipeline keeps its result; it is only presented on an enabled cycle.
  assign bus.readdatavalid = vld_c & bus.clken;
  assign bus.waitrequest   = wait_c;
  assign bus.init_done     = (state == READY);
  assign bus.err_oor       = err_q;

endmodule

// File: doc/soc2_ram_pipe.md
SOC2_RAM_PIPE -- requirements
Module: soc2_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 10240, number of words.
REQ-003 SHALL have parameter ADDR_W, default 14, word-address width; must satisfy 2**ADDR_W >= DEPTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, with 1 or 2 allowed; cycles from read accept to readdatavalid.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, zero-fill the array after reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock. All logic on rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port address, input, ADDR_W bits: word address.
REQ-009 SHALL have port byteenable, input, DATA_W/8 bits: write byte mask.
REQ-010 SHALL have port chipselect, input, 1 bit: slave select.
REQ-011 SHALL have port read, input, 1 bit: read request.
REQ-012 SHALL have port write, input, 1 bit: write request.
REQ-013 SHALL have port writedata, input, DATA_W bits: write data.
REQ-014 SHALL have port clken, input, 1 bit: clock enable; low freezes the block.
REQ-015 SHALL have port readdata, output, DATA_W bits: registered read data.
REQ-016 SHALL have port readdatavalid, output, 1 bit: one-cycle pulse qualifying readdata.
REQ-017 SHALL have port waitrequest, output, 1 bit: when high, the request is not accepted.
REQ-018 SHALL have port init_done, output, 1 bit: high once the array is ready.
REQ-019 SHALL have port err_oor, output, 1 bit: sticky flag for an out-of-range access.

Function
REQ-020 SHALL implement FSM states CLEAR and READY.
- Reset enters CLEAR when CLEAR_ON_RESET=1, else READY.
REQ-021 In CLEAR, SHALL write all-zero to address clr_cnt each clken cycle.
- clr_cnt counts 0..DEPTH-1.
- At DEPTH-1 the FSM moves to READY; the clear takes exactly DEPTH enabled cycles.
REQ-022 waitrequest SHALL equal (state==CLEAR) | ~clken.
REQ-023 init_done SHALL equal (state==READY).
REQ-024 Write accept SHALL be chipselect & write & ~waitrequest.
- Only bytes with byteenable[i]=1 are updated.
- byteenable=0 is a no-op.
REQ-025 Read accept SHALL be chipselect & read & ~write & ~waitrequest.
- read and write both high: the write is performed, the read is ignored, and no readdatavalid is produced.
REQ-026 readdata and readdatavalid SHALL appear exactly READ_LATENCY enabled cycles after a read accept.
- Back-to-back reads sustain one result per cycle.
REQ-027 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-028 Address >= DEPTH:
- a write is dropped;
- a read returns all-zero with readdatavalid;
- either case sets err_oor, which stays high until reset.
REQ-029 When clken=0, SHALL hold all state:
- read pipeline, clr_cnt, FSM and readdata are unchanged;
- readdatavalid is forced low;
- a pending result emerges after clken returns.
REQ-030 readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-031 On reset_n low, SHALL asynchronously set the following, regardless of in-flight operations:
- readdata=0, readdatavalid=0, err_oor=0, clr_cnt=0;
- read pipeline valid bits=0;
- FSM state per REQ-020.
REQ-032 Reset mid-CLEAR or mid-read SHALL restart the clear from address 0 and discard pending reads.
REQ-033 Array contents SHALL NOT be reset asynchronously; they are zeroed only via CLEAR.
REQ-034 Removal of reset SHALL be treated as synchronous to clk; the first FSM action occurs on the first rising edge with reset_n high.

Structure
REQ-035 Package soc2_ram_pkg SHALL hold:
- the FSM state enum (CLEAR, READY);
- the legal READ_LATENCY constants;
- a byte-lane count helper (DATA_W/8).
REQ-036 Sub-module soc2_ram_core SHALL hold the inferred byte-enabled single-port array, with a one-cycle synchronous read and new-data read-during-write.
- The top handles FSM, handshake, pipeline and range check.
REQ-037 Elaboration SHALL fail for DATA_W%8≠0, READ_LATENCY∉{1,2}, or 2**ADDR_W<DEPTH.

Verification
REQ-038 DEPTH=16, CLEAR_ON_RESET=1:
- release reset -> waitrequest=1 for 16 cycles, then init_done=1;
- reading addresses 0..15 returns 0x00000000.
REQ-039 Write 0xAABBCCDD to address 5 with byteenable=4'b0101 over prior 0x11223344 -> read of address 5 returns 0x11BB33DD, valid 1 cycle later (READ_LATENCY=1) or 2 cycles later (READ_LATENCY=2).
REQ-040 Reads of addresses 1, 2, 3 back-to-back -> three consecutive readdatavalid pulses in order.
- With clken dropped for 3 cycles mid-stream, no pulses occur while low and no data is lost.
REQ-041 DEPTH=10240, write to address 10240 -> memory unchanged and err_oor=1.
- A following read of address 10240 returns 0 with readdatavalid=1.
REQ-042 reset_n pulsed low at clr_cnt=8, and again during an outstanding read -> outputs zero immediately, no stale readdatavalid, and the clear restarts at address 0.
